// File: rtl/pc_gen_unit.sv
// pc_gen_unit: IF-stage program counter with prioritised trap/mret/redirect select,
// fetch handshake to imem, exception-PC capture and an accepted-fetch counter.
module pc_gen_unit #(
  parameter int               Width     = 32,
  parameter logic [Width-1:0] RESET_VEC = '0,
  parameter logic [Width-1:0] TRAP_VEC  = Width'(32'h0000_0100),
  parameter int               INC       = 4,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             redirect,
  input  logic [Width-1:0] redirect_pc,
  input  logic             trap,
  input  logic [Width-1:0] trap_pc,
  input  logic             mret,
  output logic [Width-1:0] PC,
  output logic [Width-1:0] PC_plus,
  output logic             fetch_valid,
  output logic [Width-1:0] epc,
  output logic             cause,
  output logic [CNT_W-1:0] fetch_cnt
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  localparam logic [Width-1:0] INC_V = Width'(INC);
  localparam logic [Width-1:0] MASK  = Width'(INC - 1);
  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d, epc_q, epc_d;
  logic             cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, misaligned;
  assign fetch_valid = state_q == RUN;
  assign accept      = fetch_valid & imem_ready & ~stall;
  assign misaligned  = (redirect_pc & MASK) != '0;
  assign PC          = pc_q;
  assign PC_plus     = pc_q + INC_V;
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign fetch_cnt   = cnt_q;
  // control-flow changes ignore stall/imem_ready; the counter still sees the accept
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    state_d = RUN;
    cnt_d   = cnt_q + CNT_W'(accept);
    if (trap) begin
      pc_d    = TRAP_VEC;
      epc_d   = trap_pc;
      cause_d = 1'b1;
      state_d = FLUSH;
    end else if (mret) begin
      pc_d    = epc_q;
      state_d = FLUSH;
    end else if (redirect && misaligned) begin
      pc_d    = TRAP_VEC;
      epc_d   = redirect_pc;
      cause_d = 1'b0;
      state_d = FLUSH;
    end else if (redirect) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      pc_d = PC_plus;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed stimulus, cycle-level reference model plus literal checkpoints.
module tb_pc_gen_unit;
  localparam int CW = 4;
  logic          clk = 1'b0;
  logic          reset, stall, imem_ready, redirect, trap, mret;
  logic [31:0]   redirect_pc, trap_pc;
  logic [31:0]   PC, PC_plus, epc;
  logic          fetch_valid, cause;
  logic [CW-1:0] fetch_cnt;
  int            errors = 0, checks = 0;

  pc_gen_unit #(.Width(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .INC(4), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .trap(trap), .trap_pc(trap_pc),
    .mret(mret), .PC(PC), .PC_plus(PC_plus), .fetch_valid(fetch_valid),
    .epc(epc), .cause(cause), .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: "live" means the last edge did not introduce a bubble.
  bit [31:0] m_pc, m_epc;
  bit        m_cause, m_live, m_known;
  int        m_cnt;
  always @(posedge clk) begin
    bit acc;
    if (!reset) begin
      m_pc = 32'h0; m_epc = 0; m_cause = 0; m_cnt = 0; m_live = 0; m_known = 1;
    end else if (m_known) begin
      acc = m_live && imem_ready && !stall;
      if (acc) m_cnt = (m_cnt + 1) % (1 << CW);
      if (trap) begin
        m_pc = 32'h100; m_epc = trap_pc; m_cause = 1; m_live = 0;
      end else if (mret) begin
        m_pc = m_epc; m_live = 0;
      end else if (redirect && (redirect_pc % 4) != 0) begin
        m_pc = 32'h100; m_epc = redirect_pc; m_cause = 0; m_live = 0;
      end else begin
        if (redirect) m_pc = redirect_pc;
        else if (acc) m_pc = m_pc + 4;
        m_live = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("m_pc", PC, m_pc);
      chk("m_pc_plus", PC_plus, m_pc + 32'd4);
      chk("m_valid", {31'b0, fetch_valid}, {31'b0, m_live});
      chk("m_epc", epc, m_epc);
      chk("m_cause", {31'b0, cause}, {31'b0, m_cause});
      chk("m_cnt", {28'b0, fetch_cnt}, 32'(m_cnt));
    end
  end

  task automatic drive(input logic rs, input logic st, input logic rdy, input logic rd,
                       input logic [31:0] rpc, input logic tr, input logic [31:0] tpc, input logic mr);
    reset = rs; stall = st; imem_ready = rdy; redirect = rd;
    redirect_pc = rpc; trap = tr; trap_pc = tpc; mret = mr;
    @(posedge clk); #1;
  endtask

  task automatic run(input logic rdy);
    drive(1, 0, rdy, 0, 0, 0, 0, 0);
  endtask

  initial begin
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("rst_pc", PC, 32'h0); chk("rst_valid", {31'b0, fetch_valid}, 0);
    chk("rst_epc", epc, 0); chk("rst_cnt", {28'b0, fetch_cnt}, 0);
    run(1);
    chk("boot_pc", PC, 32'h0); chk("boot_valid", {31'b0, fetch_valid}, 1);
    run(1); run(1);
    chk("seq_pc", PC, 32'h8); chk("seq_cnt", {28'b0, fetch_cnt}, 2); chk("seq_plus", PC_plus, 32'hC);
    run(0); run(0);
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    chk("hold_pc", PC, 32'h8); chk("hold_cnt", {28'b0, fetch_cnt}, 2);
    run(1);
    chk("adv_pc", PC, 32'hC); chk("adv_cnt", {28'b0, fetch_cnt}, 3);
    drive(1, 1, 1, 1, 32'hAAAA_AAA8, 0, 0, 0);
    chk("redir_pc", PC, 32'hAAAA_AAA8); chk("redir_valid", {31'b0, fetch_valid}, 1);
    chk("redir_cnt", {28'b0, fetch_cnt}, 3);
    drive(1, 0, 1, 1, 32'h5555_5555, 0, 0, 0);
    chk("mis_pc", PC, 32'h100); chk("mis_epc", epc, 32'h5555_5555);
    chk("mis_cause", {31'b0, cause}, 0); chk("mis_valid", {31'b0, fetch_valid}, 0);
    run(1);
    chk("mis_resume", {31'b0, fetch_valid}, 1); chk("mis_cnt", {28'b0, fetch_cnt}, 4);
    drive(1, 0, 1, 1, 32'h200, 1, 32'h40, 1);
    chk("trap_pc", PC, 32'h100); chk("trap_epc", epc, 32'h40);
    chk("trap_cause", {31'b0, cause}, 1); chk("trap_valid", {31'b0, fetch_valid}, 0);
    chk("trap_cnt", {28'b0, fetch_cnt}, 5);
    run(1);
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("mret_pc", PC, 32'h40); chk("mret_valid", {31'b0, fetch_valid}, 0);
    run(0);
    chk("mret_resume", {31'b0, fetch_valid}, 1);
    drive(1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("top_plus", PC_plus, 32'h0);
    run(1);
    chk("wrap_pc", PC, 32'h0); chk("wrap_plus", PC_plus, 32'h4); chk("wrap_cnt6", {28'b0, fetch_cnt}, 6);
    for (int i = 0; i < 9; i++) run(1);
    chk("cnt15", {28'b0, fetch_cnt}, 15); chk("pc24", PC, 32'h24);
    run(1);
    chk("cnt_wrap", {28'b0, fetch_cnt}, 0);
    drive(1, 0, 1, 0, 0, 1, 32'h80, 0);
    chk("pre_rst_cnt", {28'b0, fetch_cnt}, 1);
    drive(0, 0, 1, 0, 0, 1, 32'h80, 0);
    chk("mid_rst_pc", PC, 32'h0); chk("mid_rst_epc", epc, 0);
    chk("mid_rst_cnt", {28'b0, fetch_cnt}, 0); chk("mid_rst_valid", {31'b0, fetch_valid}, 0);
    chk("mid_rst_cause", {31'b0, cause}, 0);
    run(1); run(1);
    drive(1, 0, 1, 0, 0, 0, 0, 1);
    chk("mret_zero", PC, 32'h0); chk("mret_zero_cnt", {28'b0, fetch_cnt}, 2);
    run(1); run(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised program-counter generator for the 3-stage pipeline. Successor to the single-register enable-gated PC.
- Adds a reset vector, a fetch handshake to instruction memory, a prioritised next-PC select (trap / mret / redirect / sequential), and an exception-PC register with a misaligned-target check.
- Adds a bubble-inserting FSM and a fetch counter.
- Sits at the head of IF; drives imem address and pc/pc+INC into the IF/EX register.

Parameters:
- Width, 32, PC/address width.
- RESET_VEC, 32'h0000_0000, PC loaded at reset.
- TRAP_VEC, 32'h0000_0100, PC loaded on trap or misaligned redirect.
- INC, 4, sequential increment in bytes (power of 2, ≥1).
- CNT_W, 16, fetch counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-low reset (0 = reset).
- stall  in  1  pipeline stall; blocks sequential advance only.
- imem_ready  in  1  imem accepts the current fetch this cycle.
- redirect  in  1  branch/jump taken.
- redirect_pc  in  Width  branch/jump target.
- trap  in  1  exception/interrupt request.
- trap_pc  in  Width  PC of the faulting instruction.
- mret  in  1  return from trap.
- PC  out  Width  current fetch address.
- PC_plus  out  Width  PC+INC, combinational.
- fetch_valid  out  1  PC is a valid fetch request.
- epc  out  Width  saved exception PC.
- cause  out  1  0 = misaligned target, 1 = external trap; valid when epc is written.
- fetch_cnt  out  CNT_W  count of accepted fetches.

Behaviour:
- All state updates on posedge clk.
- reset=0 at an edge, regardless of any other input:
  - PC=RESET_VEC, epc=0, cause=0, fetch_cnt=0, state=BOOT.
  - Mid-operation reset discards everything, including any pending redirect.
- FSM states: BOOT, RUN, FLUSH.
  - fetch_valid=1 only in RUN.
  - BOOT → RUN after one cycle.
  - FLUSH → RUN after one cycle.
- accept = fetch_valid & imem_ready & ~stall.
  - fetch_cnt increments on accept and wraps at 2^CNT_W.
- Next-PC priority, evaluated in every state, highest first:
  1. trap: PC←TRAP_VEC, epc←trap_pc, cause←1, state←FLUSH.
  2. mret: PC←epc, state←FLUSH.
  3. redirect with redirect_pc mod INC ≠ 0: PC←TRAP_VEC, epc←redirect_pc, cause←0, state←FLUSH.
  4. redirect, aligned: PC←redirect_pc, state←RUN, no bubble.
  5. accept: PC←PC+INC, wrapping modulo 2^Width.
  6. otherwise: PC holds; state goes BOOT/FLUSH→RUN, RUN stays RUN.
- Redirect, trap and mret override stall and imem_ready; control flow is never lost.
- Simultaneous trap+mret+redirect: only trap acts; mret and redirect are dropped.
- Simultaneous trap and accept: fetch_cnt still increments.
- mret with epc unchanged since reset returns to 0.
- PC_plus = PC+INC, truncated to Width. Example: PC=FFFF_FFFC, INC=4 → PC_plus=0.
- fetch_valid and PC are held stable while imem_ready=0 (no address change without accept or redirect).

Test Plan:
1. Reset then run:
   - Stimulus: reset=0 for 2 cycles, release; imem_ready=1, stall=0.
   - Response: cycle0 PC=0, fetch_valid=0 (BOOT); then PC=0,4,8 with fetch_valid=1; fetch_cnt=3 after 3 accepts.
2. Handshake/stall hold:
   - Stimulus: at PC=0x8, drive imem_ready=0 for 2 cycles, then stall=1 for 1 cycle.
   - Response: PC stays 0x8, fetch_cnt unchanged; advances to 0xC one cycle after both clear.
3. Redirect and misalignment:
   - Stimulus: redirect=1, redirect_pc=0xAAAA_AAA8, during stall=1.
   - Response: next PC=0xAAAA_AAA8, fetch_valid stays 1.
   - Stimulus: redirect_pc=0x5555_5555.
   - Response: PC=0x100, epc=0x5555_5555, cause=0, one cycle fetch_valid=0.
4. Trap priority and mret:
   - Stimulus: trap=1, trap_pc=0x40, redirect=1, mret=1 in the same cycle.
   - Response: PC=0x100, epc=0x40, cause=1, FLUSH bubble.
   - Stimulus: later mret=1.
   - Response: PC=0x40 after a 1-cycle bubble.
5. Wrap-around:
   - Stimulus: redirect to 0xFFFF_FFFC, then accept.
   - Response: PC=0x0, PC_plus=0x4; with CNT_W=4, fetch_cnt wraps 15→0.
6. Reset mid-operation:
   - Stimulus: reset=0 while in FLUSH with trap=1.
   - Response: PC=RESET_VEC, epc=0, fetch_cnt=0, state=BOOT, trap ignored.
